// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART blocks.
// Contents:
//   PAR_NONE / PAR_EVEN / PAR_ODD : parity-mode encodings for PARITY_MODE
//   BIT_CNT_W                     : width of the per-frame bit counter
//   rx_state_e                    : receiver state encoding
//   calc_clks_per_bit()           : system clocks per serial bit (truncating)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned PAR_NONE = 32'd0;
    localparam int unsigned PAR_EVEN = 32'd1;
    localparam int unsigned PAR_ODD  = 32'd2;

    // Large enough to count up to the widest data field (9 bits).
    localparam int unsigned BIT_CNT_W = 32'd4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                      input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter. A load_half starts a half-bit period
// (used to land on the middle of a start bit); after that, and after any
// load_full, every period is a full bit. sample_tick is high for exactly one
// cycle at the end of each period, and the counter wraps on its own so a
// caller only has to reload when it wants to re-phase.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   load_half    clear the counter and time half a bit next
//   load_full    clear the counter and time a full bit next
//   sample_tick  one-cycle pulse at the end of each timed period
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 32'd1041
) (
    input  logic clk,
    input  logic reset,
    input  logic load_half,
    input  logic load_full,
    output logic sample_tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LIMIT = CW'(CLKS_PER_BIT / 32'd2 - 32'd1);
    localparam logic [CW-1:0] FULL_LIMIT = CW'(CLKS_PER_BIT - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          half_q;
    logic          half_d;
    logic          tick_q;
    logic          tick_d;

    // Next counter value; the tick is decoded from the next value so that
    // tick_q is a flop yet lines up with the counter reaching its limit.
    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        if (load_half) begin
            cnt_d  = '0;
            half_d = 1'b1;
        end else if (load_full) begin
            cnt_d  = '0;
            half_d = 1'b0;
        end else if (tick_q) begin
            cnt_d  = '0;
            half_d = 1'b0;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
        if (half_d) begin
            tick_d = (cnt_d == HALF_LIMIT);
        end else begin
            tick_d = (cnt_d == FULL_LIMIT);
        end
    end

    // Counter, phase and tick registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            tick_q <= tick_d;
        end
    end

    assign sample_tick = tick_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
// Configurable UART receiver: DATA_BITS data bits (LSB first), optional even
// or odd parity, one or two stop bits. The serial input is synchronised by a
// 2-flop chain and every decision uses the second flop. A start bit that is
// high again at its midpoint is treated as a glitch and dropped silently.
// Each completed frame produces a one-cycle o_rx_valid with the data and the
// parity / framing / break flags; erroneous frames are still delivered.
// Ports:
//   source_clk    system clock, rising edge
//   reset         synchronous, active-high
//   i_rx_serial   asynchronous serial line, idle high
//   o_rx_valid    one-cycle pulse per completed frame
//   o_RX_message  received data, held until the next valid
//   o_parity_err  parity mismatch (qualified by o_rx_valid)
//   o_frame_err   a stop bit sampled low (qualified by o_rx_valid)
//   o_break       every sampled bit was low (qualified by o_rx_valid)
//   o_rx_active   receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 32'd10_000_000,
    parameter int unsigned BAUD_RATE   = 32'd9600,
    parameter int unsigned DATA_BITS   = 32'd8,
    parameter int unsigned PARITY_MODE = 32'd0,
    parameter int unsigned STOP_BITS   = 32'd1
) (
    input  logic                 source_clk,
    input  logic                 reset,
    input  logic                 i_rx_serial,
    output logic                 o_rx_valid,
    output logic [DATA_BITS-1:0] o_RX_message,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_rx_active
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD_RATE);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 32'd1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 32'd1);
    localparam bit HAS_PARITY = (PARITY_MODE != PAR_NONE);

    if (CLKS_PER_BIT < 32'd4) begin : g_chk_cpb
        $error("uart_rx_cfg: CLKS_PER_BIT must be at least 4");
    end
    if ((DATA_BITS < 32'd5) || (DATA_BITS > 32'd9)) begin : g_chk_data
        $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE > 32'd2) begin : g_chk_par
        $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if ((STOP_BITS != 32'd1) && (STOP_BITS != 32'd2)) begin : g_chk_stop
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    // Parity bit the transmitter should have sent for the given data.
    function automatic logic parity_expected(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY_MODE == PAR_ODD) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    // Synchroniser
    logic rx_meta_q;
    logic rx_meta_d;
    logic rx_s_q;
    logic rx_s_d;

    // Frame FSM and datapath
    rx_state_e             state_q;
    rx_state_e             state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q;
    logic [DATA_BITS-1:0]  shift_d;
    logic                  par_err_q;
    logic                  par_err_d;
    logic                  frm_err_q;
    logic                  frm_err_d;
    logic                  any_one_q;   // some data/parity/stop sample was 1
    logic                  any_one_d;
    logic                  done_q;      // final stop bit sampled last edge
    logic                  done_d;
    logic                  brk_q;
    logic                  brk_d;

    // Output registers
    logic                  valid_q;
    logic                  valid_d;
    logic [DATA_BITS-1:0]  msg_q;
    logic [DATA_BITS-1:0]  msg_d;
    logic                  par_out_q;
    logic                  par_out_d;
    logic                  frm_out_q;
    logic                  frm_out_d;
    logic                  brk_out_q;
    logic                  brk_out_d;
    logic                  active_q;
    logic                  active_d;

    // Bit timer handshake
    logic load_half_s;
    logic load_full_s;
    logic sample_tick_s;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk         (source_clk),
        .reset       (reset),
        .load_half   (load_half_s),
        .load_full   (load_full_s),
        .sample_tick (sample_tick_s)
    );

    // Two-flop synchroniser feed.
    always_comb begin
        rx_meta_d = i_rx_serial;
        rx_s_d    = rx_meta_q;
    end

    // Frame sequencing: next state, sampling and error accumulation.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        any_one_d   = any_one_q;
        done_d      = 1'b0;
        brk_d       = brk_q;
        load_half_s = 1'b0;
        load_full_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d     = START;
                    load_half_s = 1'b1;
                end else begin
                    state_d     = IDLE;
                end
            end

            START: begin
                if (sample_tick_s) begin
                    if (!rx_s_q) begin
                        // Genuine start bit: re-phase to full bits and
                        // clear everything left over from the previous frame.
                        state_d     = DATA;
                        load_full_s = 1'b1;
                        bit_cnt_d   = '0;
                        shift_d     = '0;
                        par_err_d   = 1'b0;
                        frm_err_d   = 1'b0;
                        any_one_d   = 1'b0;
                        brk_d       = 1'b0;
                    end else begin
                        state_d     = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end

            DATA: begin
                if (sample_tick_s) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    any_one_d = any_one_q | rx_s_q;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        if (HAS_PARITY) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end

            PARITY: begin
                if (sample_tick_s) begin
                    par_err_d = (rx_s_q != parity_expected(shift_q));
                    any_one_d = any_one_q | rx_s_q;
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end else begin
                    state_d   = PARITY;
                end
            end

            STOP: begin
                if (sample_tick_s) begin
                    frm_err_d = frm_err_q | ~rx_s_q;
                    any_one_d = any_one_q | rx_s_q;
                    if (bit_cnt_q == STOP_LAST) begin
                        // Leave mid-stop-bit so the next start edge is never
                        // missed when the transmitter runs slightly fast.
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        brk_d     = ~(any_one_q | rx_s_q);
                        if (!(any_one_q | rx_s_q)) begin
                            state_d = WAIT_HIGH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end else begin
                    state_d = STOP;
                end
            end

            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output staging: publish the frame one edge after its last stop sample.
    always_comb begin
        valid_d  = done_q;
        active_d = (state_d != IDLE);
        if (done_q) begin
            msg_d     = shift_q;
            par_out_d = par_err_q;
            frm_out_d = frm_err_q;
            brk_out_d = brk_q;
        end else begin
            msg_d     = msg_q;
            par_out_d = 1'b0;
            frm_out_d = 1'b0;
            brk_out_d = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge source_clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            any_one_q <= 1'b0;
            done_q    <= 1'b0;
            brk_q     <= 1'b0;
            valid_q   <= 1'b0;
            msg_q     <= '0;
            par_out_q <= 1'b0;
            frm_out_q <= 1'b0;
            brk_out_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            any_one_q <= any_one_d;
            done_q    <= done_d;
            brk_q     <= brk_d;
            valid_q   <= valid_d;
            msg_q     <= msg_d;
            par_out_q <= par_out_d;
            frm_out_q <= frm_out_d;
            brk_out_q <= brk_out_d;
            active_q  <= active_d;
        end
    end

    assign o_rx_valid   = valid_q;
    assign o_RX_message = msg_q;
    assign o_parity_err = par_out_q;
    assign o_frame_err  = frm_out_q;
    assign o_break      = brk_out_q;
    assign o_rx_active  = active_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
// Five receivers run side by side, one per configuration under test:
//   0: 8N1  - plain frame, start glitch, recovery
//   1: 8E1  - good and bad parity, sent back to back
//   2: 8N2  - low second stop bit, then a clean frame
//   3: 8N1  - line break held for 12 bit times, then a clean frame
//   4: 7O1  - reset in the middle of a frame, then a clean frame
// Stimulus threads push the expected frame into a per-receiver queue before
// sending it; a monitor pops and compares whenever a receiver raises valid.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

    localparam int CPB = 1041;   // 10 MHz / 9600, truncated

    typedef struct packed {
        logic [8:0] data;
        logic       par;
        logic       frm;
        logic       brk;
    } exp_t;

    logic       clk;
    logic       rst_main;
    logic       rst_e;
    logic       rx_line [5];
    logic       valid   [5];
    logic       par     [5];
    logic       frm     [5];
    logic       brk     [5];
    logic       act     [5];
    logic [8:0] msg     [5];
    logic [7:0] msg_a, msg_b, msg_c, msg_d;
    logic [6:0] msg_e;

    exp_t exp_q [5][$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    assign msg[0] = {1'b0, msg_a};
    assign msg[1] = {1'b0, msg_b};
    assign msg[2] = {1'b0, msg_c};
    assign msg[3] = {1'b0, msg_d};
    assign msg[4] = {2'b00, msg_e};

    uart_rx_cfg u_a (
        .source_clk(clk), .reset(rst_main), .i_rx_serial(rx_line[0]),
        .o_rx_valid(valid[0]), .o_RX_message(msg_a), .o_parity_err(par[0]),
        .o_frame_err(frm[0]), .o_break(brk[0]), .o_rx_active(act[0]));

    uart_rx_cfg #(.PARITY_MODE(1)) u_b (
        .source_clk(clk), .reset(rst_main), .i_rx_serial(rx_line[1]),
        .o_rx_valid(valid[1]), .o_RX_message(msg_b), .o_parity_err(par[1]),
        .o_frame_err(frm[1]), .o_break(brk[1]), .o_rx_active(act[1]));

    uart_rx_cfg #(.STOP_BITS(2)) u_c (
        .source_clk(clk), .reset(rst_main), .i_rx_serial(rx_line[2]),
        .o_rx_valid(valid[2]), .o_RX_message(msg_c), .o_parity_err(par[2]),
        .o_frame_err(frm[2]), .o_break(brk[2]), .o_rx_active(act[2]));

    uart_rx_cfg u_d (
        .source_clk(clk), .reset(rst_main), .i_rx_serial(rx_line[3]),
        .o_rx_valid(valid[3]), .o_RX_message(msg_d), .o_parity_err(par[3]),
        .o_frame_err(frm[3]), .o_break(brk[3]), .o_rx_active(act[3]));

    uart_rx_cfg #(.DATA_BITS(7), .PARITY_MODE(2)) u_e (
        .source_clk(clk), .reset(rst_e), .i_rx_serial(rx_line[4]),
        .o_rx_valid(valid[4]), .o_RX_message(msg_e), .o_parity_err(par[4]),
        .o_frame_err(frm[4]), .o_break(brk[4]), .o_rx_active(act[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int inst,
                         input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst %0d: got 0x%0h, expected 0x%0h", name, inst, got, want);
        end
    endtask

    task automatic drive(input int idx, input logic v, input int cycles);
        rx_line[idx] = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input int idx, input int nbits, input logic [8:0] data,
                              input bit has_par, input logic par_bit, input int nstop);
        drive(idx, 1'b0, CPB);
        for (int i = 0; i < nbits; i++) drive(idx, data[i], CPB);
        if (has_par) drive(idx, par_bit, CPB);
        for (int i = 0; i < nstop; i++) drive(idx, 1'b1, CPB);
    endtask

    task automatic expect_frame(input int idx, input logic [8:0] d,
                                input logic p, input logic f, input logic b);
        exp_t e;
        e.data = d; e.par = p; e.frm = f; e.brk = b;
        exp_q[idx].push_back(e);
    endtask

    // Monitor: compare every valid against the queue; flags must be 0 otherwise.
    always @(negedge clk) begin
        if (!rst_main) begin
            for (int i = 0; i < 5; i++) begin
                if (valid[i] === 1'b1) begin
                    if (exp_q[i].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid inst %0d: got data 0x%0h, expected no valid",
                                 i, msg[i]);
                    end else begin
                        mon_e = exp_q[i].pop_front();
                        check("frame{data,par,frm,brk}", i,
                              32'({msg[i], par[i], frm[i], brk[i]}),
                              32'({mon_e.data, mon_e.par, mon_e.frm, mon_e.brk}));
                    end
                end else begin
                    check("flags_without_valid", i, 32'({par[i], frm[i], brk[i]}), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_main = 1'b1;
        rst_e    = 1'b1;
        for (int i = 0; i < 5; i++) rx_line[i] = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("reset_state", i,
                  32'({valid[i], msg[i], par[i], frm[i], brk[i], act[i]}), 32'd0);
        end
        rst_main = 1'b0;
        rst_e    = 1'b0;
        @(negedge clk);

        fork
            begin : thr_a
                expect_frame(0, 9'h03F, 1'b0, 1'b0, 1'b0);
                send_frame(0, 8, 9'h03F, 1'b0, 1'b0, 1);
                drive(0, 1'b1, CPB);
                check("active_after_frame", 0, 32'(act[0]), 32'd0);
                drive(0, 1'b0, 150);
                check("active_in_start", 0, 32'(act[0]), 32'd1);
                drive(0, 1'b0, 150);
                drive(0, 1'b1, 2 * CPB);
                check("idle_after_glitch", 0, 32'(act[0]), 32'd0);
                expect_frame(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
                send_frame(0, 8, 9'h0C3, 1'b0, 1'b0, 1);
                drive(0, 1'b1, 2 * CPB);
            end
            begin : thr_b
                // 0xA5 has four ones, so the correct even parity bit is 0.
                expect_frame(1, 9'h0A5, 1'b0, 1'b0, 1'b0);
                expect_frame(1, 9'h0A5, 1'b1, 1'b0, 1'b0);
                send_frame(1, 8, 9'h0A5, 1'b1, 1'b0, 1);
                send_frame(1, 8, 9'h0A5, 1'b1, 1'b1, 1);
                drive(1, 1'b1, 2 * CPB);
            end
            begin : thr_c
                expect_frame(2, 9'h055, 1'b0, 1'b1, 1'b0);
                send_frame(2, 8, 9'h055, 1'b0, 1'b0, 1);
                // Second stop bit low across its midpoint; the receiver is
                // idle again mid-bit, so release early enough that the low
                // tail is rejected as a start glitch.
                drive(2, 1'b0, 780);
                drive(2, 1'b1, 2 * CPB - 780);
                expect_frame(2, 9'h00F, 1'b0, 1'b0, 1'b0);
                send_frame(2, 8, 9'h00F, 1'b0, 1'b0, 2);
                drive(2, 1'b1, 2 * CPB);
            end
            begin : thr_d
                expect_frame(3, 9'h000, 1'b0, 1'b1, 1'b1);
                drive(3, 1'b0, 11 * CPB);
                check("active_in_break", 3, 32'(act[3]), 32'd1);
                drive(3, 1'b0, CPB);
                drive(3, 1'b1, 2 * CPB);
                check("idle_after_break", 3, 32'(act[3]), 32'd0);
                expect_frame(3, 9'h081, 1'b0, 1'b0, 1'b0);
                send_frame(3, 8, 9'h081, 1'b0, 1'b0, 1);
                drive(3, 1'b1, 2 * CPB);
            end
            begin : thr_e
                logic [8:0] d2a;
                d2a = 9'h02A;
                drive(4, 1'b0, CPB);
                for (int i = 0; i < 4; i++) drive(4, d2a[i], CPB);
                rx_line[4] = 1'b1;
                rst_e      = 1'b1;
                repeat (3) @(negedge clk);
                check("reset_mid_frame", 4,
                      32'({valid[4], msg[4], par[4], frm[4], brk[4], act[4]}), 32'd0);
                rst_e = 1'b0;
                drive(4, 1'b1, 2 * CPB);
                // 0x2A (7 bits) has three ones, so the odd parity bit is 0.
                expect_frame(4, 9'h02A, 1'b0, 1'b0, 1'b0);
                send_frame(4, 7, 9'h02A, 1'b1, 1'b0, 1);
                drive(4, 1'b1, 2 * CPB);
            end
        join

        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("frames_outstanding", i, 32'(exp_q[i].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
